ready_vga_sync_module: RTL

//  Raster timing generator driving the VGA display pipeline. Produces HSYNC/VSYNC,
//  the active-video qualifier Ready_Sig and pixel coordinates Column_Addr_Sig /
//  Row_Addr_Sig consumed by the *_vga_control_module blocks, which fetch ROM data.

---
 rtl/ready_vga_sync_module_pkg.sv | 43 ++++
 rtl/ready_vga_sync_module_if.sv | 29 ++
 rtl/ready_vga_sync_module_axis.sv | 51 +++++
 rtl/ready_vga_sync_module.sv | 105 ++++++++++
 4 files changed

// File: rtl/ready_vga_sync_module_pkg.sv
// Raster timing constants, axis phase enum and phase-decode helper.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package vga_timing_pkg;

  localparam int CNT_W = 11;

  // SVGA 800x600@72 on a 50 MHz pixel clock
  localparam int SVGA_H_SYNC   = 120;
  localparam int SVGA_H_BACK   = 64;
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FRONT  = 56;
  localparam int SVGA_V_SYNC   = 6;
  localparam int SVGA_V_BACK   = 23;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FRONT  = 37;

  typedef enum logic [1:0] {
    PH_SYNC   = 2'd0,
    PH_BACK   = 2'd1,
    PH_ACTIVE = 2'd2,
    PH_FRONT  = 2'd3
  } phase_e;

  function automatic int axis_total(input int s, input int b, input int a, input int f);
    return s + b + a + f;
  endfunction

  localparam int SVGA_H_TOTAL = axis_total(SVGA_H_SYNC, SVGA_H_BACK, SVGA_H_ACTIVE, SVGA_H_FRONT);
  localparam int SVGA_V_TOTAL = axis_total(SVGA_V_SYNC, SVGA_V_BACK, SVGA_V_ACTIVE, SVGA_V_FRONT);

  // Phase is a pure function of the count, so it can never disagree with it.
  function automatic phase_e phase_of(input logic [CNT_W-1:0] cnt,
                                      input int s, input int b, input int a);
    int c;
    c = int'(cnt);
    if (c < s)              return PH_SYNC;
    else if (c < s + b)     return PH_BACK;
    else if (c < s + b + a) return PH_ACTIVE;
    else                    return PH_FRONT;
  endfunction

endpackage

// File: rtl/ready_vga_sync_module_if.sv
// Timing-generator bundle: enable in, sync/qualifier/coordinates out.
// Latency: wires only.
// Backpressure: none; En low freezes the producer.
interface ready_vga_sync_module_if;
  import vga_timing_pkg::*;

  logic             En;
  logic             HSYNC_Sig;
  logic             VSYNC_Sig;
  logic             Ready_Sig;
  logic [CNT_W-1:0] Column_Addr_Sig;
  logic [CNT_W-1:0] Row_Addr_Sig;
  logic             Frame_Start_Sig;

  // Timing generator side
  modport master (
    input  En,
    output HSYNC_Sig, VSYNC_Sig, Ready_Sig,
    output Column_Addr_Sig, Row_Addr_Sig, Frame_Start_Sig
  );

  // Display/control side
  modport slave (
    output En,
    input  HSYNC_Sig, VSYNC_Sig, Ready_Sig,
    input  Column_Addr_Sig, Row_Addr_Sig, Frame_Start_Sig
  );

endinterface

// File: rtl/ready_vga_sync_module_axis.sv
// One raster axis: wrapping counter plus SYNC/BACK/ACTIVE/FRONT decode.
// Latency: count registered; phase and wrap strobe combinational from count.
// Backpressure: i_en low holds the count; wrap only asserts on an enabled last count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int SYNC   = SVGA_H_SYNC,
  parameter int BACK   = SVGA_H_BACK,
  parameter int ACTIVE = SVGA_H_ACTIVE,
  parameter int FRONT  = SVGA_H_FRONT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output phase_e           o_phase,
  output logic             o_wrap
);

  localparam int               TOTAL = axis_total(SYNC, BACK, ACTIVE, FRONT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_wrap;

  // Count register; reset restarts the axis at the SYNC phase.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_count <= '0;
    else     r_count <= w_count_nxt;
  end

  // Next count and wrap strobe; the wrap strobe doubles as the next axis' enable.
  always_comb begin
    w_count_nxt = r_count;
    w_wrap      = 1'b0;
    if (i_en) begin
      if (r_count == LAST) begin
        w_count_nxt = '0;
        w_wrap      = 1'b1;
      end else begin
        w_count_nxt = r_count + 1'b1;
      end
    end
  end

  assign o_count = r_count;
  assign o_phase = phase_of(r_count, SYNC, BACK, ACTIVE);
  assign o_wrap  = w_wrap;

endmodule

// File: rtl/ready_vga_sync_module.sv
// Raster timing generator: HSYNC/VSYNC, Ready_Sig, pixel coordinates, frame-start pulse.
// Latency: every output is registered, 1 CLK behind the (hc,vc) counters.
// Backpressure: En low freezes counters and outputs; Frame_Start_Sig still drops after one cycle.
module ready_vga_sync_module
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC   = SVGA_H_SYNC,
  parameter int H_BACK   = SVGA_H_BACK,
  parameter int H_ACTIVE = SVGA_H_ACTIVE,
  parameter int H_FRONT  = SVGA_H_FRONT,
  parameter int V_SYNC   = SVGA_V_SYNC,
  parameter int V_BACK   = SVGA_V_BACK,
  parameter int V_ACTIVE = SVGA_V_ACTIVE,
  parameter int V_FRONT  = SVGA_V_FRONT,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                   CLK,
  input  logic                   RST,
  ready_vga_sync_module_if.master vga
);

  localparam logic [CNT_W-1:0] H_OFS = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] V_OFS = CNT_W'(V_SYNC + V_BACK);

  logic [CNT_W-1:0] w_hc;
  logic [CNT_W-1:0] w_vc;
  phase_e           w_h_phase;
  phase_e           w_v_phase;
  logic             w_h_wrap;

  vga_axis_counter #(
    .SYNC(H_SYNC), .BACK(H_BACK), .ACTIVE(H_ACTIVE), .FRONT(H_FRONT)
  ) u_h_axis (
    .CLK     (CLK),
    .RST     (RST),
    .i_en    (vga.En),
    .o_count (w_hc),
    .o_phase (w_h_phase),
    .o_wrap  (w_h_wrap)
  );

  vga_axis_counter #(
    .SYNC(V_SYNC), .BACK(V_BACK), .ACTIVE(V_ACTIVE), .FRONT(V_FRONT)
  ) u_v_axis (
    .CLK     (CLK),
    .RST     (RST),
    .i_en    (w_h_wrap),
    .o_count (w_vc),
    .o_phase (w_v_phase),
    .o_wrap  ()
  );

  logic             w_ready;
  logic [CNT_W-1:0] w_col;
  logic [CNT_W-1:0] w_row;
  logic             w_frame_start;

  // Decode of the current raster position, registered below.
  always_comb begin
    w_ready       = (w_h_phase == PH_ACTIVE) && (w_v_phase == PH_ACTIVE);
    w_col         = '0;
    w_row         = '0;
    if (w_ready) begin
      w_col = w_hc - H_OFS;
      w_row = w_vc - V_OFS;
    end
    w_frame_start = w_ready && (w_col == '0) && (w_row == '0);
  end

  logic             r_hsync;
  logic             r_vsync;
  logic             r_ready;
  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;
  logic             r_frame_start;

  // Output registers: hold while disabled, except the frame-start pulse which always clears.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_ready       <= 1'b0;
      r_col         <= '0;
      r_row         <= '0;
      r_frame_start <= 1'b0;
    end else if (vga.En) begin
      r_hsync       <= (w_h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= (w_v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      r_ready       <= w_ready;
      r_col         <= w_col;
      r_row         <= w_row;
      r_frame_start <= w_frame_start;
    end else begin
      r_frame_start <= 1'b0;
    end
  end

  assign vga.HSYNC_Sig       = r_hsync;
  assign vga.VSYNC_Sig       = r_vsync;
  assign vga.Ready_Sig       = r_ready;
  assign vga.Column_Addr_Sig = r_col;
  assign vga.Row_Addr_Sig    = r_row;
  assign vga.Frame_Start_Sig = r_frame_start;

endmodule
